// File: rtl/scan_mux_pkg.sv
// Shared types and width helper for the scan_mux channel multiplexer.
package scan_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MANUAL,
        ST_SCAN
    } state_e;

    // Select/tag width; a 2-channel mux still needs one select bit.
    function automatic int sel_width(input int n);
        sel_width = (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_mux_next_ch.sv
// Wrap-around priority search over an enable mask: next enabled channel after cur_i,
// lowest enabled channel, and an any-enabled flag. Purely combinational.
module scan_mux_next_ch #(
    parameter int NCH  = 16,
    parameter int SELW = 4
) (
    input  logic [NCH-1:0]  mask_i,
    input  logic [SELW-1:0] cur_i,
    output logic [SELW-1:0] nxt_o,
    output logic [SELW-1:0] lowest_o,
    output logic            any_o
);

    logic found;
    int   idx;

    // Kept apart from the next-channel search: the parent feeds lowest_o back into cur_i.
    always_comb begin
        any_o = |mask_i;
    end

    always_comb begin
        lowest_o = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_i[i]) lowest_o = SELW'(i);
        end
    end

    always_comb begin
        nxt_o = cur_i;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = int'(cur_i) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && mask_i[idx]) begin
                nxt_o = SELW'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_mux.sv
// Registered NCH:1 channel mux, manual or auto-scan, 1-cycle latency; output beat held while
// y_valid && !y_ready. SCAN_MUX_MASK_EN adds ch_mask to skip disabled channels during scan.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int NCH  = 16,
    parameter int W    = 8,
    parameter int SELW = sel_width(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*W-1:0]  in,
    input  logic              en,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
`ifdef SCAN_MUX_MASK_EN
    input  logic [NCH-1:0]    ch_mask,
`endif
    output logic [W-1:0]      y_data,
    output logic [SELW-1:0]   y_sel,
    output logic              y_last,
    output logic              y_valid,
    input  logic              y_ready,
    output logic              sel_err
);

    state_e            state_q, state_d;
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [W-1:0]      y_data_q, y_data_d;
    logic [SELW-1:0]   y_sel_q, y_sel_d;
    logic              y_last_q, y_last_d;
    logic              y_valid_q, y_valid_d;
    logic              sel_err_q, sel_err_d;

    logic [NCH-1:0]    mask;
    logic [SELW-1:0]   cur, nxt, lowest;
    logic              any_en, entering, ld_ok;

`ifdef SCAN_MUX_MASK_EN
    assign mask = ch_mask;
`else
    assign mask = '1;
`endif

    // A fresh scan frame starts at the lowest enabled channel, not wherever ptr was left.
    assign entering = (state_q != ST_SCAN);
    assign cur      = entering ? lowest : ptr_q;
    assign ld_ok    = !y_valid_q || y_ready;

    scan_mux_next_ch #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_next_ch (
        .mask_i   (mask),
        .cur_i    (cur),
        .nxt_o    (nxt),
        .lowest_o (lowest),
        .any_o    (any_en)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        y_data_d  = y_data_q;
        y_sel_d   = y_sel_q;
        y_last_d  = y_last_q;
        y_valid_d = y_valid_q;
        sel_err_d = 1'b0;
        if (ld_ok) begin
            if (!en)       state_d = ST_IDLE;
            else if (!mode) state_d = ST_MANUAL;
            else           state_d = ST_SCAN;
            y_valid_d = 1'b0;
            case (state_d)
                ST_MANUAL: begin
                    if (int'(sel) < NCH) begin
                        y_data_d  = in[int'(sel)*W +: W];
                        y_sel_d   = sel;
                        y_last_d  = 1'b0;
                        y_valid_d = 1'b1;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
                ST_SCAN: begin
                    ptr_d = cur;
                    if (any_en) begin
                        y_data_d  = in[int'(cur)*W +: W];
                        y_sel_d   = cur;
                        // The search wrapping (or staying put) means cur is the highest enabled channel.
                        y_last_d  = (nxt <= cur);
                        y_valid_d = 1'b1;
                        ptr_d     = nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            y_data_q  <= '0;
            y_sel_q   <= '0;
            y_last_q  <= 1'b0;
            y_valid_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            y_data_q  <= y_data_d;
            y_sel_q   <= y_sel_d;
            y_last_q  <= y_last_d;
            y_valid_q <= y_valid_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign y_data  = y_data_q;
    assign y_sel   = y_sel_q;
    assign y_last  = y_last_q;
    assign y_valid = y_valid_q;
    assign sel_err = sel_err_q;

endmodule
